carry_resolve: RTL and testbench

Limb-serial carry-propagation stage directly downstream of the constant multiplier in the BN254 datapath. It accepts one redundant polynomial per transaction: N_LIMB limbs, each W_LIMB data bits plus CB carry bits, as produced by the x1/x2/x3/x4/x6 constant-multiply stage. It resolves the carries one limb per cycle and returns the canonical non-redundant integer. A valid/ready handshake on both sides lets it sit between the constant-multiply stage and the downstream modular reduction or packing logic.

---
 rtl/carry_resolve_pkg.sv | 17 +
 rtl/carry_resolve_if.sv | 27 ++
 rtl/carry_resolve_limb_add.sv | 17 +
 rtl/carry_resolve.sv | 120 ++++++++++++
 tb/tb_carry_resolve.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/carry_resolve_pkg.sv
// Shared BN254 datapath constants, limb typedefs and the carry_resolve FSM state type.
package PARAMS_BN254_d0;

  localparam int LIMB_W      = 16;
  localparam int CARRY_GUARD = 3;
  localparam int ADD_DIV     = 4;

  typedef logic [LIMB_W+CARRY_GUARD-1:0]       red_limb_t;
  typedef logic [ADD_DIV*LIMB_W+CARRY_GUARD:0] resolved_t;

  typedef enum logic [1:0] {
    IDLE,
    PROP,
    DONE
  } carry_resolve_state_t;

endpackage

// File: rtl/carry_resolve_if.sv
// Valid/ready bus between the constant-multiply stage, carry_resolve and the downstream consumer.
interface carry_resolve_if
  import PARAMS_BN254_d0::*;
#(
  parameter int N_LIMB = ADD_DIV,
  parameter int W_LIMB = LIMB_W,
  parameter int CB     = CARRY_GUARD
);

  logic                            in_valid;
  logic                            in_ready;
  logic [N_LIMB*(W_LIMB+CB)-1:0]   din;
  logic                            out_valid;
  logic                            out_ready;
  logic [N_LIMB*W_LIMB+CB:0]       dout;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout
  );

endinterface

// File: rtl/carry_resolve_limb_add.sv
// Combinational limb-plus-carry adder; the full-width sum splits into {carry, res}.
module limb_add #(
  parameter int W_LIMB = 16,
  parameter int CB     = 3
) (
  input  logic [W_LIMB+CB-1:0] i_limb,
  input  logic [CB:0]          i_carry,
  output logic [W_LIMB-1:0]    o_res,
  output logic [CB:0]          o_carry
);

  logic [W_LIMB+CB:0] w_sum;

  assign w_sum            = {1'b0, i_limb} + {{W_LIMB{1'b0}}, i_carry};
  assign {o_carry, o_res} = w_sum;

endmodule

// File: rtl/carry_resolve.sv
// Limb-serial carry resolution of a redundant polynomial into a canonical integer.
// Optional CARRY_RESOLVE_SKIP_EN bypasses propagation when no limb carries any carry bits.
module carry_resolve
  import PARAMS_BN254_d0::*;
#(
  parameter int N_LIMB = ADD_DIV,
  parameter int W_LIMB = LIMB_W,
  parameter int CB     = CARRY_GUARD
) (
  input  logic             clk,
  input  logic             rstn,
  carry_resolve_if.slave   bus,
  output logic             busy
);

  localparam int LW = W_LIMB + CB;
  localparam int DW = N_LIMB * W_LIMB + CB + 1;
  localparam int IW = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;

  carry_resolve_state_t r_state, w_nextState;

  logic [N_LIMB*LW-1:0] r_buf;
  logic [CB:0]          r_carry;
  logic [IW-1:0]        r_idx;
  logic [DW-1:0]        r_dout;

  logic [LW-1:0]        w_limb;
  logic [W_LIMB-1:0]    w_res;
  logic [CB:0]          w_carry;
  logic                 w_lastLimb;
  logic                 w_skip;

  assign w_limb     = r_buf[r_idx*LW +: LW];
  assign w_lastLimb = (r_idx == IW'(N_LIMB - 1));
  assign bus.dout   = r_dout;

  limb_add #(
    .W_LIMB (W_LIMB),
    .CB     (CB)
  ) u_limbAdd (
    .i_limb  (w_limb),
    .i_carry (r_carry),
    .o_res   (w_res),
    .o_carry (w_carry)
  );

`ifdef CARRY_RESOLVE_SKIP_EN
  logic [DW-1:0] w_skipDout;

  // A carry-free input is already canonical: just drop the guard bits of each limb.
  always_comb begin
    w_skip     = 1'b1;
    w_skipDout = '0;
    for (int i = 0; i < N_LIMB; i++) begin
      if (bus.din[i*LW+W_LIMB +: CB] != '0) w_skip = 1'b0;
      w_skipDout[i*W_LIMB +: W_LIMB] = bus.din[i*LW +: W_LIMB];
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) w_nextState = w_skip ? DONE : PROP;
      end
      PROP: begin
        if (w_lastLimb) w_nextState = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Result limbs are written straight into dout, so it is already complete on entry to DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf   <= '0;
      r_carry <= '0;
      r_idx   <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_buf   <= bus.din;
            r_carry <= '0;
            r_idx   <= '0;
`ifdef CARRY_RESOLVE_SKIP_EN
            if (w_skip) r_dout <= w_skipDout;
`endif
          end
        end
        PROP: begin
          r_dout[r_idx*W_LIMB +: W_LIMB] <= w_res;
          r_carry                        <= w_carry;
          r_idx                          <= r_idx + 1'b1;
          if (w_lastLimb) r_dout[DW-1 -: CB+1] <= w_carry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_resolve.sv
// Randomized and directed bench for carry_resolve against an arithmetic reference model.
module tb_carry_resolve;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int CB   = 3;
  localparam int LW   = W + CB;
  localparam int DINW = N * LW;
  localparam int DW   = N * W + CB + 1;

  logic clk;
  logic rstn;
  logic busy;
  int   checks;
  int   errors;

  carry_resolve_if #(.N_LIMB(N), .W_LIMB(W), .CB(CB)) bus ();

  carry_resolve #(
    .N_LIMB (N),
    .W_LIMB (W),
    .CB     (CB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The integer value of a redundant polynomial is the weighted sum of its limbs.
  function automatic logic [DW-1:0] refResolve(input logic [DINW-1:0] v);
    logic [DW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc + (DW'(v[i*LW +: LW]) << (W * i));
    return acc;
  endfunction

  function automatic int refLatency(input logic [DINW-1:0] v);
    int lat;
    lat = N + 1;
`ifdef CARRY_RESOLVE_SKIP_EN
    lat = 1;
    for (int i = 0; i < N; i++) if (v[i*LW+W +: CB] != '0) lat = N + 1;
`endif
    return lat;
  endfunction

  function automatic logic [DINW-1:0] mk(input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                                          input logic [LW-1:0] l2, input logic [LW-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [DINW-1:0] randVec(input bit noCarry);
    logic [DINW-1:0] v;
    logic [LW-1:0]   l;
    v = '0;
    for (int i = 0; i < N; i++) begin
      l = LW'($urandom);
      if (noCarry) l[LW-1:W] = '0;
      v[i*LW +: LW] = l;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One transaction: offer, measure latency, optionally stall the consumer, then release.
  task automatic applyStimulus(input logic [DINW-1:0] vec, input int holdCycles,
                               input bit pulseIn, input string tag);
    int            waitCnt;
    int            lat;
    logic [DW-1:0] exp;
    exp           = refResolve(vec);
    bus.din       = vec;
    bus.in_valid  = 1'b1;
    bus.out_ready = (holdCycles == 0);
    waitCnt       = 0;
    while (!bus.in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.in_ready) checkOutput({tag, "_accept_timeout"}, 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat          = 1;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, refLatency(vec));
    checkOutput({tag, "_dout"}, bus.dout, exp);
    for (int c = 0; c < holdCycles; c++) begin
      if (pulseIn) begin
        bus.in_valid = c[0];
        bus.din      = randVec(1'b0);
      end
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, bus.out_valid, 1);
      checkOutput({tag, "_hold_in_ready"}, bus.in_ready, 0);
      checkOutput({tag, "_hold_dout"}, bus.dout, exp);
    end
    bus.in_valid  = 1'b0;
    bus.din       = vec;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_released"}, bus.out_valid, 0);
    checkOutput({tag, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  task automatic resetMidOp(input logic [DINW-1:0] vec);
    bus.din       = vec;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_prop_busy", busy, 1);
    rstn = 1'b0;
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_dout", bus.dout, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_output", bus.out_valid, 0);
  endtask

  task automatic backToBack();
    logic [DINW-1:0] vecs [3];
    int sent, got, cyc, lastOut;
    bit acc;
    for (int i = 0; i < 3; i++) begin
      vecs[i]       = randVec(1'b0);
      vecs[i][W]    = 1'b1;
    end
    sent          = 0;
    got           = 0;
    cyc           = 0;
    lastOut       = 0;
    bus.din       = vecs[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (got < 3 && cyc < 100) begin
      acc = bus.in_ready && bus.in_valid;
      if (bus.out_valid) begin
        checkOutput($sformatf("b2b_dout%0d", got), bus.dout, refResolve(vecs[got]));
        if (got > 0) checkOutput($sformatf("b2b_gap%0d", got), cyc - lastOut, 6);
        lastOut = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 3) bus.din = vecs[sent];
        else          bus.in_valid = 1'b0;
      end
    end
    if (got < 3) checkOutput("b2b_timeout", got, 3);
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [DINW-1:0] ripple;
    checks        = 0;
    errors        = 0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.din       = '0;
    ripple        = mk(19'h10000, 19'h0FFFF, 19'h0FFFF, 19'h0FFFF);
    #2;
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_dout", bus.dout, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    applyStimulus(mk(19'h00005, 19'h00005, 19'h00005, 19'h00005), 0, 1'b0, "no_carry");
    applyStimulus(ripple, 0, 1'b0, "ripple");
    checkOutput("ripple_spec_value", refResolve(ripple), 68'h1 << 64);
    applyStimulus(mk(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF), 0, 1'b0, "worst");
    applyStimulus(mk(19'h7FFFF, 19'h00001, 19'h40000, 19'h0FFFF), 10, 1'b1, "backpressure");

    resetMidOp(ripple);
    applyStimulus(ripple, 0, 1'b0, "post_reset");

    for (int t = 0; t < 16; t++)
      applyStimulus(randVec($urandom_range(0, 2) == 0), $urandom_range(0, 3), 1'b0,
                    $sformatf("rand%0d", t));

    backToBack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
